// File: rtl/note_sched_if.sv
// note_sched_if -- spawn-pattern handshake between the pattern source and note_sched.
//   pat_valid : source -> scheduler, a spawn pattern is offered
//   pat_lanes : source -> scheduler, lanes receiving a new note (bit n = lane n)
//   pat_ready : scheduler -> source, high while the one-entry pattern buffer is empty
interface note_sched_if;
    logic       pat_valid;
    logic [3:0] pat_lanes;
    logic       pat_ready;

    modport master (output pat_valid, output pat_lanes, input pat_ready);
    modport slave  (input pat_valid, input pat_lanes, output pat_ready);
endinterface

// File: rtl/note_sched.sv
// note_sched -- four-lane falling-note scheduler, judge and renderer for a rhythm game.
//
// Notes enter at the top slot of each lane from a one-entry spawn buffer and move down
// one slot every SCROLL_DIV frames. Button presses are judged against the bottom two
// slots, points and pulses are reported, and the lane field is drawn into the VGA pixel
// stream with one clock of latency.
//
// Ports
//   clk, rst    : system clock, synchronous active-high reset
//   key[3:0]    : raw lane buttons, active-high, asynchronous
//   vs          : VGA vertical sync, active-low pulse, asynchronous
//   row_addr    : current pixel row (0..479)
//   col_addr    : current pixel column (0..639)
//   rdn         : low while the pixel is visible
//   pat         : spawn-pattern handshake (note_sched_if.slave)
//   d_out       : registered {R,G,B} pixel colour, 4 bits per channel
//   score       : accumulated points, saturating at 65535
//   combo       : consecutive-hit count (0 unless NOTE_SCHED_COMBO_EN)
//   hit_pulse   : one-clk pulse the cycle after any hit
//   miss_pulse  : one-clk pulse the cycle after any miss
//
// Configuration
//   NOTE_SCHED_COMBO_EN : when defined, combo counts hits (saturating at 255) and clears
//                         on any miss; when undefined combo is held at 0.
module note_sched #(
    parameter int unsigned SCROLL_DIV = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key,
    input  logic        vs,
    input  logic [8:0]  row_addr,
    input  logic [9:0]  col_addr,
    input  logic        rdn,
    note_sched_if.slave pat,
    output logic [11:0] d_out,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic        hit_pulse,
    output logic        miss_pulse
);

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

    // ---------------------------------------------------------------- synchronisers
    logic       vs_meta, vs_sync, vs_last;
    logic [3:0] key_meta, key_sync, key_last;
    logic       frame_tick;
    logic [3:0] press;

    // vs flops reset high and key flops low so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_meta  <= 1'b1;
            vs_sync  <= 1'b1;
            vs_last  <= 1'b1;
            key_meta <= '0;
            key_sync <= '0;
            key_last <= '0;
        end else begin
            vs_meta  <= vs;
            vs_sync  <= vs_meta;
            vs_last  <= vs_sync;
            key_meta <= key;
            key_sync <= key_meta;
            key_last <= key_sync;
        end
    end

    assign frame_tick = vs_last & ~vs_sync;
    assign press      = key_sync & ~key_last;

    // ---------------------------------------------------------------- frame divider
    logic [3:0] frame_cnt;
    logic       shift;

    assign shift = frame_tick && (frame_cnt == 4'(SCROLL_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= shift ? '0 : frame_cnt + 4'd1;
        end
    end

    // ---------------------------------------------------------------- spawn buffer
    buf_state_t buf_state, buf_next;
    logic [3:0] buf_lanes;
    logic       accept;
    logic [3:0] inject;

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_state <= BUF_EMPTY;
            buf_lanes <= '0;
        end else begin
            buf_state <= buf_next;
            if (accept) begin
                buf_lanes <= pat.pat_lanes;
            end
        end
    end

    // An accept can only happen while empty, so a coincident shift injects zeros and
    // the freshly accepted pattern waits for the following shift.
    always_comb begin
        buf_next = buf_state;
        accept   = 1'b0;
        case (buf_state)
            BUF_EMPTY: begin
                accept = pat.pat_valid;
                if (accept) begin
                    buf_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (shift) begin
                    buf_next = BUF_EMPTY;
                end
            end
            default: buf_next = BUF_EMPTY;
        endcase
    end

    assign pat.pat_ready = (buf_state == BUF_EMPTY);
    assign inject        = (buf_state == BUF_FULL) ? buf_lanes : '0;

    // ---------------------------------------------------------------- lanes and judging
    logic [14:0] slot_q  [4];
    logic [14:0] slot_d  [4];
    logic [14:0] cleared [4];
    logic [3:0]  perfect, good, miss;
    logic [3:0]  points;
    logic [2:0]  hit_cnt;
    logic [16:0] score_sum;
    logic [15:0] score_d;
    logic [7:0]  combo_d;
`ifdef NOTE_SCHED_COMBO_EN
    logic [8:0]  combo_sum;
`endif

    // Hits are judged on pre-shift contents; the hit slot is cleared before the shift
    // moves the lane, so a note that was hit can never also be counted as a miss.
    always_comb begin
        points  = '0;
        hit_cnt = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            perfect[n]      = press[n] & slot_q[n][14];
            good[n]         = press[n] & ~slot_q[n][14] & slot_q[n][13];
            miss[n]         = shift & slot_q[n][14] & ~perfect[n];
            cleared[n]      = slot_q[n];
            cleared[n][14]  = slot_q[n][14] & ~perfect[n];
            cleared[n][13]  = slot_q[n][13] & ~good[n];
            slot_d[n]       = shift ? {cleared[n][13:0], inject[n]} : cleared[n];
            points          = points + {2'b00, perfect[n], good[n]};
            hit_cnt         = hit_cnt + {2'b00, perfect[n] | good[n]};
        end

        score_sum = {1'b0, score} + {13'd0, points};
        score_d   = score_sum[16] ? '1 : score_sum[15:0];

`ifdef NOTE_SCHED_COMBO_EN
        combo_sum = {1'b0, combo} + {6'd0, hit_cnt};
        if (|miss) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[8] ? '1 : combo_sum[7:0];
        end
`else
        combo_d = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < 4; n++) begin
                slot_q[n] <= '0;
            end
            score      <= '0;
            combo      <= '0;
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 4; n++) begin
                slot_q[n] <= slot_d[n];
            end
            score      <= score_d;
            combo      <= combo_d;
            hit_pulse  <= |(perfect | good);
            miss_pulse <= |miss;
        end
    end

    // ---------------------------------------------------------------- renderer
    logic [1:0]  pix_lane;
    logic        in_lanes;
    logic [3:0]  pix_slot;
    logic        note_here;
    logic [11:0] lane_rgb;
    logic [11:0] pix_d;

    always_comb begin
        pix_lane  = 2'd0;
        in_lanes  = 1'b0;
        pix_slot  = row_addr[8:5];
        note_here = 1'b0;
        lane_rgb  = 12'h000;
        pix_d     = 12'h000;

        if (col_addr >= 10'd160 && col_addr < 10'd480) begin
            in_lanes = 1'b1;
            if (col_addr < 10'd240) begin
                pix_lane = 2'd0;
            end else if (col_addr < 10'd320) begin
                pix_lane = 2'd1;
            end else if (col_addr < 10'd400) begin
                pix_lane = 2'd2;
            end else begin
                pix_lane = 2'd3;
            end
        end

        // Row band 15 lies below the visible area and never carries a note.
        if (pix_slot != 4'd15) begin
            note_here = slot_q[pix_lane][pix_slot];
        end

        case (pix_lane)
            2'd0:    lane_rgb = 12'hF00;
            2'd1:    lane_rgb = 12'h0F0;
            2'd2:    lane_rgb = 12'h00F;
            default: lane_rgb = 12'hFF0;
        endcase

        if (rdn || !in_lanes) begin
            pix_d = 12'h000;
        end else if (note_here) begin
            pix_d = lane_rgb;
        end else if (pix_slot == 4'd14 && key_sync[pix_lane]) begin
            pix_d = 12'h444;
        end else begin
            pix_d = 12'h111;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_out <= '0;
        end else begin
            d_out <= pix_d;
        end
    end

endmodule

// File: tb/tb_note_sched.sv
module tb_note_sched;
    localparam int DIV = 4;
`ifdef NOTE_SCHED_COMBO_EN
    localparam bit COMBO_ON = 1'b1;
`else
    localparam bit COMBO_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  key;
    logic        vs;
    logic [8:0]  row_addr;
    logic [9:0]  col_addr;
    logic        rdn;
    logic [11:0] d_out;
    logic [15:0] score;
    logic [7:0]  combo;
    logic        hit_pulse, miss_pulse;
    note_sched_if pif();

    // Second instance with SCROLL_DIV=1 so score saturation is reachable quickly.
    logic [3:0]  key_f;
    logic        vs_f;
    logic [11:0] f_d_out;
    logic [15:0] f_score;
    logic [7:0]  f_combo;
    logic        f_hit, f_miss;
    note_sched_if fif();

    note_sched #(.SCROLL_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .key(key), .vs(vs), .row_addr(row_addr), .col_addr(col_addr),
        .rdn(rdn), .pat(pif), .d_out(d_out), .score(score), .combo(combo),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    note_sched #(.SCROLL_DIV(1)) dut_fast (
        .clk(clk), .rst(rst), .key(key_f), .vs(vs_f), .row_addr(9'd0), .col_addr(10'd0),
        .rdn(1'b1), .pat(fif), .d_out(f_d_out), .score(f_score), .combo(f_combo),
        .hit_pulse(f_hit), .miss_pulse(f_miss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1);
    end

    int compared = 0;
    int mismatched = 0;
    int hp_cnt = 0;
    int mp_cnt = 0;

    always @(negedge clk) begin
        if (hit_pulse === 1'b1) hp_cnt++;
        if (miss_pulse === 1'b1) mp_cnt++;
    end

    // ---------------------------------------------------------------- reference model
    bit       m_slot [4][15];
    bit       m_buf_full;
    bit [3:0] m_buf;
    int       m_fc, m_score, m_combo;

    task automatic model_reset();
        for (int l = 0; l < 4; l++)
            for (int s = 0; s < 15; s++) m_slot[l][s] = 1'b0;
        m_buf_full = 1'b0; m_buf = 4'd0; m_fc = 0; m_score = 0; m_combo = 0;
    endtask

    // One judged cycle: presses first, then (maybe) a shift, then (maybe) a buffer load.
    task automatic model_step(input bit [3:0] pmask, input bit tick, input bit accept,
                              input bit [3:0] lanes, output bit ev_hit, output bit ev_miss);
        int pts, nh;
        bit do_shift;
        pts = 0; nh = 0; ev_miss = 1'b0; do_shift = 1'b0;
        if (tick) begin
            m_fc = (m_fc + 1) % DIV;
            do_shift = (m_fc == 0);
        end
        for (int l = 0; l < 4; l++) begin
            if (pmask[l]) begin
                if (m_slot[l][14]) begin pts += 2; nh++; m_slot[l][14] = 1'b0; end
                else if (m_slot[l][13]) begin pts += 1; nh++; m_slot[l][13] = 1'b0; end
            end
        end
        if (do_shift) begin
            for (int l = 0; l < 4; l++) begin
                if (m_slot[l][14]) ev_miss = 1'b1;
                for (int s = 14; s > 0; s--) m_slot[l][s] = m_slot[l][s-1];
                m_slot[l][0] = m_buf_full & m_buf[l];
            end
            m_buf_full = 1'b0;
        end
        if (accept) begin m_buf_full = 1'b1; m_buf = lanes; end
        ev_hit = (nh > 0);
        m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
        if (COMBO_ON) m_combo = ev_miss ? 0 : ((m_combo + nh > 255) ? 255 : m_combo + nh);
    endtask

    function automatic logic [11:0] exp_pix(input int row, input int col, input bit rd,
                                            input bit [3:0] held);
        int lane, slot;
        if (rd || col < 160 || col > 479) return 12'h000;
        lane = (col - 160) / 80;
        slot = row / 32;
        if (slot < 15 && m_slot[lane][slot]) begin
            case (lane)
                0: return 12'hF00;
                1: return 12'h0F0;
                2: return 12'h00F;
                default: return 12'hFF0;
            endcase
        end
        if (slot == 14 && held[lane]) return 12'h444;
        return 12'h111;
    endfunction

    // ---------------------------------------------------------------- stimulus tasks
    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();
    endtask

    task automatic do_op(input logic [3:0] pmask, input bit tick, output bit eh, output bit em,
                         output int hd, output int md);
        int h0, m0;
        h0 = hp_cnt; m0 = mp_cnt;
        @(negedge clk); key = pmask; if (tick) vs = 1'b0;
        @(negedge clk); vs = 1'b1;
        @(negedge clk); key = 4'b0000;
        repeat (6) @(negedge clk);
        model_step(pmask, tick, 1'b0, 4'b0000, eh, em);
        hd = hp_cnt - h0; md = mp_cnt - m0;
    endtask

    // Offers a pattern exactly in the cycle in which the frame tick is judged.
    task automatic do_accept_tick(input logic [3:0] lanes, output bit eh, output bit em,
                                  output int hd, output int md);
        int h0, m0;
        bit acc;
        h0 = hp_cnt; m0 = mp_cnt; acc = !m_buf_full;
        @(negedge clk); vs = 1'b0;
        @(negedge clk); vs = 1'b1;
        @(negedge clk); pif.pat_valid = 1'b1; pif.pat_lanes = lanes;
        @(negedge clk); pif.pat_valid = 1'b0;
        repeat (5) @(negedge clk);
        model_step(4'b0000, 1'b1, acc, lanes, eh, em);
        hd = hp_cnt - h0; md = mp_cnt - m0;
    endtask

    task automatic send_pattern(input logic [3:0] lanes);
        bit eh, em, acc;
        acc = !m_buf_full;
        @(negedge clk); pif.pat_valid = 1'b1; pif.pat_lanes = lanes;
        @(negedge clk); pif.pat_valid = 1'b0;
        model_step(4'b0000, 1'b0, acc, lanes, eh, em);
    endtask

    task automatic shifts(input int n, output int hd, output int md);
        int a, b;
        bit eh, em;
        hd = 0; md = 0;
        repeat (n * DIV) begin
            do_op(4'b0000, 1'b1, eh, em, a, b);
            hd += a; md += b;
        end
    endtask

    task automatic read_pix(input int row, input int col, input bit rd, output logic [11:0] v);
        @(negedge clk); row_addr = row[8:0]; col_addr = col[9:0]; rdn = rd;
        @(negedge clk); v = d_out;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++; if (pif.pat_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", pif.pat_ready); end
        compared++; if (score !== 16'd0) begin mismatched++; $display("FAIL reset_score: got %0d expected 0", score); end
        compared++; if (combo !== 8'd0) begin mismatched++; $display("FAIL reset_combo: got %0d expected 0", combo); end
        compared++; if ({hit_pulse, miss_pulse} !== 2'b00) begin mismatched++; $display("FAIL reset_pulses: got %b expected 00", {hit_pulse, miss_pulse}); end
        compared++; if (d_out !== 12'h000) begin mismatched++; $display("FAIL reset_dout: got %h expected 000", d_out); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_saturation();
        repeat (16) begin @(negedge clk); vs_f = 1'b0; @(negedge clk); vs_f = 1'b1; end
        repeat (8191) begin
            @(negedge clk); vs_f = 1'b0; key_f = 4'hF;
            @(negedge clk); vs_f = 1'b1; key_f = 4'h0;
        end
        repeat (6) @(negedge clk);
        compared++; if (f_score !== 16'd65528) begin mismatched++; $display("FAIL sat_bulk: got %0d expected 65528", f_score); end
        compared++; if (f_combo !== (COMBO_ON ? 8'd255 : 8'd0)) begin mismatched++; $display("FAIL sat_combo: got %0d expected %0d", f_combo, COMBO_ON ? 255 : 0); end
        @(negedge clk); key_f = 4'b0111; @(negedge clk); key_f = 4'h0; repeat (6) @(negedge clk);
        compared++; if (f_score !== 16'd65534) begin mismatched++; $display("FAIL sat_65534: got %0d expected 65534", f_score); end
        @(negedge clk); key_f = 4'b1000; @(negedge clk); key_f = 4'h0; repeat (6) @(negedge clk);
        compared++; if (f_score !== 16'd65535) begin mismatched++; $display("FAIL sat_perfect: got %0d expected 65535", f_score); end
        @(negedge clk); key_f = 4'b1111; @(negedge clk); key_f = 4'h0; repeat (6) @(negedge clk);
        compared++; if (f_score !== 16'd65535) begin mismatched++; $display("FAIL sat_hold: got %0d expected 65535", f_score); end
        compared++; if (f_combo !== (COMBO_ON ? 8'd255 : 8'd0)) begin mismatched++; $display("FAIL sat_combo_hold: got %0d expected %0d", f_combo, COMBO_ON ? 255 : 0); end
    endtask

    task automatic test_scroll();
        logic [11:0] v;
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b0001);
        compared++; if (pif.pat_ready !== 1'b0) begin mismatched++; $display("FAIL scroll_ready_drop: got %b expected 0", pif.pat_ready); end
        repeat (3) do_op(4'b0000, 1'b1, eh, em, hd, md);
        compared++; if (pif.pat_ready !== 1'b0) begin mismatched++; $display("FAIL scroll_ready_hold: got %b expected 0", pif.pat_ready); end
        do_op(4'b0000, 1'b1, eh, em, hd, md);
        compared++; if (pif.pat_ready !== 1'b1) begin mismatched++; $display("FAIL scroll_ready_back: got %b expected 1", pif.pat_ready); end
        read_pix(5, 170, 1'b0, v);
        compared++; if (v !== 12'hF00) begin mismatched++; $display("FAIL scroll_pix_note: got %h expected F00", v); end
        read_pix(5, 170, 1'b1, v);
        compared++; if (v !== 12'h000) begin mismatched++; $display("FAIL scroll_pix_blank: got %h expected 000", v); end
        read_pix(5, 100, 1'b0, v);
        compared++; if (v !== 12'h000) begin mismatched++; $display("FAIL scroll_pix_outside: got %h expected 000", v); end
        read_pix(37, 170, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL scroll_pix_empty: got %h expected 111", v); end
        @(negedge clk); key = 4'b0010;
        repeat (3) @(negedge clk);
        read_pix(460, 250, 1'b0, v);
        compared++; if (v !== 12'h444) begin mismatched++; $display("FAIL scroll_pix_held: got %h expected 444", v); end
        key = 4'b0000;
        repeat (6) @(negedge clk);
        model_step(4'b0010, 1'b0, 1'b0, 4'b0000, eh, em);
    endtask

    task automatic test_perfect();
        logic [11:0] v;
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b0100);
        shifts(15, hd, md);
        read_pix(451, 325, 1'b0, v);
        compared++; if (v !== 12'h00F) begin mismatched++; $display("FAIL perf_arrive: got %h expected 00F", v); end
        do_op(4'b0100, 1'b0, eh, em, hd, md);
        compared++; if (score !== 16'd2) begin mismatched++; $display("FAIL perf_score: got %0d expected 2", score); end
        compared++; if (hd !== 1) begin mismatched++; $display("FAIL perf_hit_pulse: got %0d cycles expected 1", hd); end
        read_pix(451, 325, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL perf_cleared: got %h expected 111", v); end
        shifts(1, hd, md);
        compared++; if (md !== 0) begin mismatched++; $display("FAIL perf_no_miss: got %0d expected 0", md); end
    endtask

    task automatic test_miss();
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b0011);
        shifts(15, hd, md);
        do_op(4'b0001, 1'b0, eh, em, hd, md);
        compared++; if (combo !== (COMBO_ON ? 8'd1 : 8'd0)) begin mismatched++; $display("FAIL miss_combo_pre: got %0d expected %0d", combo, COMBO_ON ? 1 : 0); end
        shifts(1, hd, md);
        compared++; if (md !== 1) begin mismatched++; $display("FAIL miss_pulse: got %0d cycles expected 1", md); end
        compared++; if (combo !== 8'd0) begin mismatched++; $display("FAIL miss_combo: got %0d expected 0", combo); end
        compared++; if (score !== 16'd2) begin mismatched++; $display("FAIL miss_score: got %0d expected 2", score); end
    endtask

    task automatic test_good_coincident();
        logic [11:0] v;
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b1000);
        shifts(14, hd, md);
        repeat (3) do_op(4'b0000, 1'b1, eh, em, hd, md);
        read_pix(417, 401, 1'b0, v);
        compared++; if (v !== 12'hFF0) begin mismatched++; $display("FAIL good_slot13: got %h expected FF0", v); end
        do_op(4'b1000, 1'b1, eh, em, hd, md);
        compared++; if (score !== 16'd1) begin mismatched++; $display("FAIL good_score: got %0d expected 1", score); end
        compared++; if (hd !== 1 || md !== 0) begin mismatched++; $display("FAIL good_pulses: got hit %0d miss %0d expected 1 0", hd, md); end
        read_pix(460, 401, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL good_absent: got %h expected 111", v); end
        shifts(1, hd, md);
        compared++; if (md !== 0) begin mismatched++; $display("FAIL good_no_miss: got %0d expected 0", md); end
    endtask

    task automatic test_all_lanes();
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b1111);
        shifts(15, hd, md);
        do_op(4'b1111, 1'b0, eh, em, hd, md);
        compared++; if (score !== 16'd8) begin mismatched++; $display("FAIL all_score: got %0d expected 8", score); end
        compared++; if (hd !== 1) begin mismatched++; $display("FAIL all_hit_pulse: got %0d cycles expected 1", hd); end
        compared++; if (combo !== (COMBO_ON ? 8'd4 : 8'd0)) begin mismatched++; $display("FAIL all_combo: got %0d expected %0d", combo, COMBO_ON ? 4 : 0); end
    endtask

    task automatic test_accept_on_shift();
        logic [11:0] v;
        bit eh, em;
        int hd, md;
        do_reset();
        repeat (3) do_op(4'b0000, 1'b1, eh, em, hd, md);
        do_accept_tick(4'b0101, eh, em, hd, md);
        compared++; if (pif.pat_ready !== 1'b0) begin mismatched++; $display("FAIL aos_ready: got %b expected 0", pif.pat_ready); end
        read_pix(2, 165, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL aos_not_yet: got %h expected 111", v); end
        repeat (4) do_op(4'b0000, 1'b1, eh, em, hd, md);
        read_pix(2, 165, 1'b0, v);
        compared++; if (v !== 12'hF00) begin mismatched++; $display("FAIL aos_lane0: got %h expected F00", v); end
        read_pix(2, 330, 1'b0, v);
        compared++; if (v !== 12'h00F) begin mismatched++; $display("FAIL aos_lane2: got %h expected 00F", v); end
        read_pix(2, 250, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL aos_lane1: got %h expected 111", v); end
    endtask

    task automatic test_reset_mid();
        logic [11:0] v;
        bit eh, em;
        int hd, md;
        do_reset();
        send_pattern(4'b1111);
        shifts(15, hd, md);
        do_op(4'b1111, 1'b0, eh, em, hd, md);
        @(negedge clk);
        pif.pat_valid = 1'b1; pif.pat_lanes = 4'b0010; vs = 1'b0; rst = 1'b1;
        row_addr = 9'd5; col_addr = 10'd170; rdn = 1'b0;
        @(negedge clk);
        compared++; if (pif.pat_ready !== 1'b1) begin mismatched++; $display("FAIL rmid_ready: got %b expected 1", pif.pat_ready); end
        compared++; if (score !== 16'd0 || combo !== 8'd0) begin mismatched++; $display("FAIL rmid_counts: got score %0d combo %0d expected 0 0", score, combo); end
        compared++; if ({hit_pulse, miss_pulse} !== 2'b00 || d_out !== 12'h000) begin mismatched++; $display("FAIL rmid_outs: got pulses %b d_out %h expected 00 000", {hit_pulse, miss_pulse}, d_out); end
        rst = 1'b0; pif.pat_valid = 1'b0; vs = 1'b1;
        model_reset();
        shifts(1, hd, md);
        compared++; if (hd !== 0 || md !== 0) begin mismatched++; $display("FAIL rmid_pulses_after: got hit %0d miss %0d expected 0 0", hd, md); end
        read_pix(5, 250, 1'b0, v);
        compared++; if (v !== 12'h111) begin mismatched++; $display("FAIL rmid_discarded: got %h expected 111", v); end
    endtask

    task automatic test_random();
        logic [11:0] v, e;
        bit eh, em, rd;
        int hd, md, r, row, col;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 9);
            hd = 0; md = 0; eh = 0; em = 0;
            if (r <= 1) send_pattern(4'($urandom_range(1, 15)));
            else if (r <= 5) do_op(4'b0000, 1'b1, eh, em, hd, md);
            else if (r <= 7) do_op(4'($urandom_range(0, 15)), 1'b0, eh, em, hd, md);
            else if (r == 8) do_op(4'($urandom_range(0, 15)), 1'b1, eh, em, hd, md);
            else do_accept_tick(4'($urandom_range(1, 15)), eh, em, hd, md);
            compared++; if (score !== 16'(m_score)) begin mismatched++; $display("FAIL rand_score it%0d: got %0d expected %0d", it, score, m_score); end
            compared++; if (combo !== 8'(m_combo)) begin mismatched++; $display("FAIL rand_combo it%0d: got %0d expected %0d", it, combo, m_combo); end
            compared++; if (pif.pat_ready !== !m_buf_full) begin mismatched++; $display("FAIL rand_ready it%0d: got %b expected %b", it, pif.pat_ready, !m_buf_full); end
            compared++; if (hd !== int'(eh) || md !== int'(em)) begin mismatched++; $display("FAIL rand_pulses it%0d: got hit %0d miss %0d expected %0d %0d", it, hd, md, eh, em); end
            if (it % 40 == 39) begin
                for (int l = 0; l < 4; l++) begin
                    for (int s = 0; s < 15; s++) begin
                        row = s * 32 + $urandom_range(0, 31);
                        col = 160 + l * 80 + $urandom_range(0, 79);
                        rd = ($urandom_range(0, 7) == 0);
                        read_pix(row, col, rd, v);
                        e = exp_pix(row, col, rd, 4'b0000);
                        compared++; if (v !== e) begin mismatched++; $display("FAIL rand_pix r%0d c%0d: got %h expected %h", row, col, v, e); end
                    end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; vs = 1'b1; key = 4'b0000; row_addr = '0; col_addr = '0; rdn = 1'b1;
        pif.pat_valid = 1'b0; pif.pat_lanes = 4'b0000;
        vs_f = 1'b1; key_f = 4'b0000; fif.pat_valid = 1'b1; fif.pat_lanes = 4'hF;
        model_reset();
        test_reset();
        test_saturation();
        test_scroll();
        test_perfect();
        test_miss();
        test_good_coincident();
        test_all_lanes();
        test_accept_on_shift();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
